// File: rtl/macinv_pkg.sv
// Shared types and helpers for the m_macinv_bank polarity buffer.
package macinv_pkg;

  localparam int unsigned DEF_CHANNELS = 2;

  typedef logic [DEF_CHANNELS-1:0] chan_vec_t;

  // Stability counter width; never zero so the bypass configuration still elaborates.
  function automatic int unsigned cnt_width(int unsigned filt);
    return (filt == 0) ? 1 : $clog2(filt + 1);
  endfunction

  function automatic logic [63:0] pol_ones(int unsigned n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/m_macinv_bank_chan.sv
// One polarity-buffer channel: sample flop, stability filter, data and change pipelines.
module m_macinv_chan
  import macinv_pkg::*;
#(
  parameter int unsigned FILT    = 0,
  parameter int unsigned DEPTH   = 1,
  parameter logic        POL_RST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  input  logic pol,
  output logic q,
  output logic chg
);

  localparam int unsigned CW = cnt_width(FILT);

  logic             s;
  logic             f;
  logic             upd_c;
  logic             flag;
  logic [DEPTH-1:0] dpipe;
  logic [DEPTH-1:0] cpipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s <= 1'b0;
    else     s <= i;
  end

  generate
    if (FILT == 0) begin : g_nofilt
      assign f     = s;
      assign upd_c = (i != s);
    end else begin : g_filt
      logic [CW-1:0] cnt;
      logic          fr;

      // Accept a change only after FILT consecutive differing samples.
      assign upd_c = (s != fr) && (cnt == CW'(FILT - 1));
      assign f     = fr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fr  <= 1'b0;
          cnt <= '0;
        end else if (s == fr) begin
          cnt <= '0;
        end else if (upd_c) begin
          fr  <= s;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

  // Change flag lines up with F so CHG reaches the output with the new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag <= 1'b0;
    else     flag <= upd_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dpipe <= {DEPTH{POL_RST}};
      cpipe <= '0;
    end else begin
      dpipe[0] <= f ^ pol;
      cpipe[0] <= flag;
      for (int k = 1; k < DEPTH; k++) begin
        dpipe[k] <= dpipe[k-1];
        cpipe[k] <= cpipe[k-1];
      end
    end
  end

  assign q   = dpipe[DEPTH-1];
  assign chg = cpipe[DEPTH-1];

endmodule

// File: rtl/m_macinv_bank.sv
// N-channel programmable-polarity buffer with optional deglitch and retimed outputs.
module m_macinv_bank
  import macinv_pkg::*;
#(
  parameter int unsigned          CHANNELS = 2,
  parameter int unsigned          FILT     = 0,
  parameter int unsigned          DEPTH    = 1,
  parameter logic [CHANNELS-1:0]  POL_RST  = CHANNELS'(pol_ones(CHANNELS))
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] I,
  input  logic                POL_WR,
  input  logic [CHANNELS-1:0] POL_D,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] CHG,
  output logic [CHANNELS-1:0] POL
);

  // Polarity register is shared so all channels switch on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       POL <= POL_RST;
    else if (POL_WR) POL <= POL_D;
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      m_macinv_chan #(
        .FILT    (FILT),
        .DEPTH   (DEPTH),
        .POL_RST (POL_RST[g])
      ) u_chan (
        .clk (CLK),
        .rst (RESET),
        .i   (I[g]),
        .pol (POL[g]),
        .q   (Q[g]),
        .chg (CHG[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_m_macinv_bank.sv
// Directed bench for m_macinv_bank across four parameter configurations.
module tb_m_macinv_bank;
  import macinv_pkg::*;

  typedef struct {
    chan_vec_t i;
    logic      wr;
    chan_vec_t d;
    chan_vec_t q;
    chan_vec_t chg;
    chan_vec_t pol;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_d, rst_dd;
  assign rst_dd = rst | rst_d;

  chan_vec_t ia, da, qa, chga, pola;
  chan_vec_t ib, db, qb, chgb, polb;
  chan_vec_t ic, dc, qc, chgc, polc;
  chan_vec_t id, dd, qd, chgd, pold;
  logic wra, wrb, wrc, wrd;

  int total = 0;
  int bad   = 0;
  vec_t tbl[12];

  m_macinv_bank #(.CHANNELS(2), .FILT(0), .DEPTH(1)) dut_a (
    .CLK(clk), .RESET(rst), .I(ia), .POL_WR(wra), .POL_D(da), .Q(qa), .CHG(chga), .POL(pola));
  m_macinv_bank #(.CHANNELS(2), .FILT(3), .DEPTH(1)) dut_b (
    .CLK(clk), .RESET(rst), .I(ib), .POL_WR(wrb), .POL_D(db), .Q(qb), .CHG(chgb), .POL(polb));
  m_macinv_bank #(.CHANNELS(2), .FILT(0), .DEPTH(3)) dut_c (
    .CLK(clk), .RESET(rst), .I(ic), .POL_WR(wrc), .POL_D(dc), .Q(qc), .CHG(chgc), .POL(polc));
  m_macinv_bank #(.CHANNELS(2), .FILT(4), .DEPTH(2)) dut_d (
    .CLK(clk), .RESET(rst_dd), .I(id), .POL_WR(wrd), .POL_D(dd), .Q(qd), .CHG(chgd), .POL(pold));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input chan_vec_t act, input chan_vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // i, wr, d, q, chg, pol  (FILT=0, DEPTH=1)
    tbl[0]  = '{2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11};
    tbl[1]  = '{2'b01, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11};
    tbl[2]  = '{2'b01, 1'b0, 2'b00, 2'b10, 2'b01, 2'b11};
    tbl[3]  = '{2'b01, 1'b0, 2'b00, 2'b10, 2'b00, 2'b11};
    tbl[4]  = '{2'b10, 1'b0, 2'b00, 2'b10, 2'b00, 2'b11};
    tbl[5]  = '{2'b10, 1'b0, 2'b00, 2'b01, 2'b11, 2'b11};
    tbl[6]  = '{2'b10, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00};
    tbl[7]  = '{2'b10, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00};
    tbl[8]  = '{2'b11, 1'b1, 2'b10, 2'b10, 2'b00, 2'b10};
    tbl[9]  = '{2'b11, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10};
    tbl[10] = '{2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 2'b10};
    tbl[11] = '{2'b00, 1'b0, 2'b00, 2'b10, 2'b11, 2'b10};

    rst = 1'b1; rst_d = 1'b0;
    ia = '0; da = '0; wra = 1'b0;
    ib = '0; db = '0; wrb = 1'b0;
    ic = '0; dc = '0; wrc = 1'b0;
    id = '0; dd = '0; wrd = 1'b0;
    #12;
    chk("rst_q",   qa,   2'b11);
    chk("rst_chg", chga, 2'b00);
    chk("rst_pol", pola, 2'b11);
    chk("rst_qd",  qd,   2'b11);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 12; n++) begin
      ia  = tbl[n].i;
      wra = tbl[n].wr;
      da  = tbl[n].d;
      step();
      chk($sformatf("tbl_q%0d", n),   qa,   tbl[n].q);
      chk($sformatf("tbl_chg%0d", n), chga, tbl[n].chg);
      chk($sformatf("tbl_pol%0d", n), pola, tbl[n].pol);
    end
    wra = 1'b0;

    // Polarity write on the same edge that samples a new input.
    ia = 2'b00; wra = 1'b1; da = 2'b11;
    step();
    wra = 1'b0;
    step(); step();
    chk("sim_pre_q", qa, 2'b11);
    ia = 2'b10; wra = 1'b1; da = 2'b00;
    step();
    wra = 1'b0;
    chk("sim_e1_q",   qa,   2'b11);
    chk("sim_e1_pol", pola, 2'b00);
    step();
    chk("sim_e2_q",   qa,   2'b10);
    chk("sim_e2_chg", chga, 2'b10);
    step();
    chk("sim_e3_chg", chga, 2'b00);

    // FILT=3: two-sample glitch is rejected.
    ib = 2'b01;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) ib = 2'b00;
      step();
      chk($sformatf("rej_q%0d", k),   qb,   2'b11);
      chk($sformatf("rej_chg%0d", k), chgb, 2'b00);
    end

    // FILT=3: held change reaches Q after edge 5.
    ib = 2'b01;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("acc_q%0d", e),   qb,   (e >= 5) ? 2'b10 : 2'b11);
      chk($sformatf("acc_chg%0d", e), chgb, (e == 5) ? 2'b01 : 2'b00);
    end

    // FILT=3: toggling every cycle never gets through.
    for (int k = 0; k < 8; k++) begin
      ib[1] = ~ib[1];
      step();
      chk($sformatf("tog_q%0d", k),   qb,   2'b10);
      chk($sformatf("tog_chg%0d", k), chgb, 2'b00);
    end

    // DEPTH=3: polarity change appears k+3 edges later, no CHG.
    wrc = 1'b1; dc = 2'b01;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (e == 1) wrc = 1'b0;
      chk($sformatf("pw_q%0d", e),   qc,   (e >= 4) ? 2'b01 : 2'b11);
      chk($sformatf("pw_chg%0d", e), chgc, 2'b00);
      chk($sformatf("pw_pol%0d", e), polc, 2'b01);
    end

    // FILT=4, DEPTH=2: baseline latency 1+4+2.
    id = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("d_q%0d", e),   qd,   (e >= 7) ? 2'b10 : 2'b11);
      chk($sformatf("d_chg%0d", e), chgd, (e == 7) ? 2'b01 : 2'b00);
    end

    // Reset with a count of 2 in flight, then full latency again.
    id = 2'b00;
    step(); step(); step();
    chk("mr_pre_q", qd, 2'b10);
    #2;
    rst_d = 1'b1;
    #1;
    chk("mr_q",   qd,   2'b11);
    chk("mr_chg", chgd, 2'b00);
    chk("mr_pol", pold, 2'b11);
    id = 2'b01;
    step();
    chk("mr_hold_q", qd, 2'b11);
    @(negedge clk);
    rst_d = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("mr_q%0d", e),   qd,   (e >= 7) ? 2'b10 : 2'b11);
      chk($sformatf("mr_chg%0d", e), chgd, (e == 7) ? 2'b01 : 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
